bsg_bladerunner_rom_arbiter: RTL

Shares one combinational `configuration_rom` instance between `num_req_p` independent readers, for example the manycore ROM endpoint, the host MMIO readout path and a debug port. Each cycle it grants one request by round-robin, drives the ROM address and captures the data into a one-entry response slot owned by the winning requester. It sits directly in front of the ROM, so the ROM itself is never duplicated.

---
 rtl/bsg_bladerunner_rom_pkg.sv | 18 +
 rtl/bsg_bladerunner_rom_arbiter_rr.sv | 46 ++++
 rtl/bsg_bladerunner_rom_arbiter.sv | 113 +++++++++++
 3 files changed

// File: rtl/bsg_bladerunner_rom_pkg.sv
// Shared types and helpers for the BladeRunner configuration-ROM access path.
//   bsg_rom_resp_s         : one response slot {err, data} at the default data width
//   bsg_rom_arb_reset_ptr  : priority pointer value after reset; pointing at the
//                            last requester makes requester 0 the first winner
package bsg_bladerunner_rom_pkg;

   localparam int unsigned bsg_rom_data_width_gp = 32;

   typedef struct packed {
      logic                             err;
      logic [bsg_rom_data_width_gp-1:0] data;
   } bsg_rom_resp_s;

   function automatic int unsigned bsg_rom_arb_reset_ptr(input int unsigned num_req);
      return (num_req > 0) ? num_req - 1 : 0;
   endfunction

endpackage

// File: rtl/bsg_bladerunner_rom_arbiter_rr.sv
// Round-robin arbiter, at most one grant per cycle.
//   clk_i, reset_n_i : clock, synchronous active-low reset
//   reqs_i           : request vector
//   grants_o         : one-hot grant (or zero), combinational from reqs_i
//   yumi_i           : grant was taken; advances the priority pointer to the winner
module bsg_arb_round_robin
   import bsg_bladerunner_rom_pkg::*;
#(
   parameter int unsigned width_p = 2
) (
   input  logic               clk_i,
   input  logic               reset_n_i,
   input  logic [width_p-1:0] reqs_i,
   output logic [width_p-1:0] grants_o,
   input  logic               yumi_i
);

   localparam int unsigned lg_width_lp = (width_p > 1) ? $clog2(width_p) : 1;

   logic [lg_width_lp-1:0] last_q, last_d;
   logic [lg_width_lp-1:0] idx, win;
   logic                   found;

   // Search starts one past the last winner and wraps around.
   always_comb begin
      grants_o = '0;
      win      = last_q;
      found    = 1'b0;
      idx      = '0;
      for (int unsigned k = 1; k <= width_p; k++) begin
         idx = lg_width_lp'((32'(last_q) + k) % width_p);
         if (!found && reqs_i[idx]) begin
            found         = 1'b1;
            grants_o[idx] = 1'b1;
            win           = idx;
         end
      end
      last_d = (yumi_i && found) ? win : last_q;
   end

   always_ff @(posedge clk_i) begin
      if (!reset_n_i) last_q <= lg_width_lp'(bsg_rom_arb_reset_ptr(width_p));
      else            last_q <= last_d;
   end

endmodule

// File: rtl/bsg_bladerunner_rom_arbiter.sv
// Shares one combinational configuration ROM between num_req_p readers.
// One request is granted per cycle (round robin); the ROM word is captured
// into a one-entry response slot owned by the winner.
//   clk_i, reset_n_i : clock, synchronous active-low reset
//   req_v_i/req_addr_i/req_ready_o : per-requester valid, word address, grant
//   rom_addr_o/rom_data_i          : external combinational ROM port
//   resp_v_o/resp_data_o/resp_err_o/resp_yumi_i : per-requester response slot
module bsg_bladerunner_rom_arbiter
   import bsg_bladerunner_rom_pkg::*;
#(
   parameter int unsigned num_req_p     = 2,
   parameter int unsigned rom_width_p   = 8,
   parameter int unsigned rom_els_p     = 16,
   parameter int unsigned data_width_p  = 32,
   parameter int unsigned lg_rom_els_lp = (rom_els_p > 1) ? $clog2(rom_els_p) : 1
) (
   input  logic                                clk_i,
   input  logic                                reset_n_i,
   input  logic [num_req_p-1:0]                req_v_i,
   input  logic [num_req_p*lg_rom_els_lp-1:0]  req_addr_i,
   output logic [num_req_p-1:0]                req_ready_o,
   output logic [lg_rom_els_lp-1:0]            rom_addr_o,
   input  logic [rom_width_p-1:0]              rom_data_i,
   output logic [num_req_p-1:0]                resp_v_o,
   output logic [num_req_p*data_width_p-1:0]   resp_data_o,
   output logic [num_req_p-1:0]                resp_err_o,
   input  logic [num_req_p-1:0]                resp_yumi_i
);

   typedef struct packed {
      logic                    err;
      logic [data_width_p-1:0] data;
   } resp_slot_s;

   logic [num_req_p-1:0]     elig, raw_grant, grant, resp_v;
   logic                     any_grant;
   logic [lg_rom_els_lp-1:0] sel_addr, rom_addr_q, rom_addr_d;
   logic                     oob;
   resp_slot_s               capture;

   // A full slot that is not draining this cycle cannot accept a new word,
   // so it drops out of arbitration instead of stalling everyone else.
   assign elig = req_v_i & (~resp_v | resp_yumi_i);

   bsg_arb_round_robin #(
      .width_p (num_req_p)
   ) arb (
      .clk_i     (clk_i),
      .reset_n_i (reset_n_i),
      .reqs_i    (elig),
      .grants_o  (raw_grant),
      .yumi_i    (any_grant)
   );

   assign grant       = reset_n_i ? raw_grant : '0;
   assign any_grant   = |grant;
   assign req_ready_o = grant;
   assign resp_v_o    = resp_v;

   always_comb begin
      sel_addr = '0;
      for (int unsigned i = 0; i < num_req_p; i++) begin
         if (grant[i]) sel_addr = sel_addr | req_addr_i[i*lg_rom_els_lp +: lg_rom_els_lp];
      end
   end

   // The ROM address only moves on a grant so idle cycles do not toggle it.
   always_comb begin
      rom_addr_o   = any_grant ? sel_addr : rom_addr_q;
      rom_addr_d   = rom_addr_o;
      oob          = (32'(rom_addr_o) >= rom_els_p);
      capture.err  = oob;
      capture.data = oob ? '0 : data_width_p'(rom_data_i);
   end

   always_ff @(posedge clk_i) begin
      if (!reset_n_i) rom_addr_q <= '0;
      else            rom_addr_q <= rom_addr_d;
   end

   for (genvar i = 0; i < num_req_p; i++) begin : g_slot
      logic       resp_v_q, resp_v_d;
      resp_slot_s resp_q, resp_d;

      // A grant wins over a same-cycle yumi: the old word leaves and the new
      // one lands on the same edge. Data/err hold after a plain yumi.
      always_comb begin
         resp_v_d = resp_v_q;
         resp_d   = resp_q;
         if (grant[i]) begin
            resp_v_d = 1'b1;
            resp_d   = capture;
         end else if (resp_yumi_i[i]) begin
            resp_v_d = 1'b0;
         end
      end

      always_ff @(posedge clk_i) begin
         if (!reset_n_i) begin
            resp_v_q <= 1'b0;
            resp_q   <= '0;
         end else begin
            resp_v_q <= resp_v_d;
            resp_q   <= resp_d;
         end
      end

      assign resp_v[i]                                    = resp_v_q;
      assign resp_err_o[i]                                = resp_q.err;
      assign resp_data_o[i*data_width_p +: data_width_p]  = resp_q.data;
   end

endmodule
